avalon_pio_irq: RTL

//  Parametrised general-purpose I/O peripheral on the Nios II Avalon-MM bus; next generation of the

---
 rtl/avalon_pio_irq_if.sv | 30 +++
 rtl/avalon_pio_irq.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/avalon_pio_irq_if.sv
`default_nettype none
// ============================================================================
//  Module   : avalon_pio_irq_if
//  Brief    : Avalon-MM slave bus bundle for the avalon_pio_irq GPIO peripheral
//  Revision : 1.0
// ============================================================================
interface avalon_pio_irq_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    output readdata
  );
endinterface
`default_nettype wire

// File: rtl/avalon_pio_irq.sv
`default_nettype none
// ============================================================================
//  Module   : avalon_pio_irq
//  Brief    : Avalon-MM GPIO with per-bit direction, input synchroniser, edge
//             capture, interrupt mask and level IRQ. Optional macro
//             PIO_SETCLR_EN adds atomic OUTSET (addr 4) / OUTCLR (addr 5).
//  Revision : 1.0
// ============================================================================
module avalon_pio_irq #(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [DATA_WIDTH-1:0] DIR_RESET   = '1,
  parameter int                    EDGE_TYPE   = 0
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  avalon_pio_irq_if.slave            bus,
  input  wire logic [DATA_WIDTH-1:0] pio_in,
  output logic      [DATA_WIDTH-1:0] pio_out,
  output logic      [DATA_WIDTH-1:0] pio_oe,
  output logic                       irq
);

  localparam logic [2:0] c_ADDR_DATA   = 3'd0;
  localparam logic [2:0] c_ADDR_DIR    = 3'd1;
  localparam logic [2:0] c_ADDR_MASK   = 3'd2;
  localparam logic [2:0] c_ADDR_EDGE   = 3'd3;
`ifdef PIO_SETCLR_EN
  localparam logic [2:0] c_ADDR_OUTSET = 3'd4;
  localparam logic [2:0] c_ADDR_OUTCLR = 3'd5;
`endif

  logic [DATA_WIDTH-1:0] r_out;
  logic [DATA_WIDTH-1:0] r_dir;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [DATA_WIDTH-1:0] r_edge;
  logic [DATA_WIDTH-1:0] r_s1;
  logic [DATA_WIDTH-1:0] r_s2;
  logic [DATA_WIDTH-1:0] r_s3;
  logic                  r_irq;
  logic [31:0]           r_readdata;

  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_detect;
  logic [DATA_WIDTH-1:0] w_out_nxt;
  logic [DATA_WIDTH-1:0] w_edge_clr;
  logic [DATA_WIDTH-1:0] w_edge_nxt;
  logic                  w_wr_dir;
  logic                  w_wr_mask;
  logic                  w_wr_edge;
  logic [31:0]           w_rd_mux;

  assign w_wdata = bus.writedata[DATA_WIDTH-1:0];

  generate
    if (DATA_WIDTH < 32) begin : g_unused_upper
      logic w_unused_wdata;
      assign w_unused_wdata = ^bus.writedata[31:DATA_WIDTH];
    end
  endgenerate

  // Edge detection looks at the two oldest synchroniser stages so s2 is metastability-free.
  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign w_detect = r_s2 & ~r_s3;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign w_detect = ~r_s2 & r_s3;
    end else begin : g_any
      assign w_detect = r_s2 ^ r_s3;
    end
  endgenerate

  always_comb begin
    w_out_nxt = r_out;
    w_wr_dir  = 1'b0;
    w_wr_mask = 1'b0;
    w_wr_edge = 1'b0;
    if (bus.write) begin
      case (bus.address)
        c_ADDR_DATA:   w_out_nxt = w_wdata;
        c_ADDR_DIR:    w_wr_dir  = 1'b1;
        c_ADDR_MASK:   w_wr_mask = 1'b1;
        c_ADDR_EDGE:   w_wr_edge = 1'b1;
`ifdef PIO_SETCLR_EN
        c_ADDR_OUTSET: w_out_nxt = r_out | w_wdata;
        c_ADDR_OUTCLR: w_out_nxt = r_out & ~w_wdata;
`endif
        default:       w_out_nxt = r_out;
      endcase
    end
  end

  // A fresh detect overrides a simultaneous write-1-to-clear so no event is lost.
  assign w_edge_clr = w_wr_edge ? w_wdata : '0;
  assign w_edge_nxt = (r_edge & ~w_edge_clr) | w_detect;

  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      c_ADDR_DATA: w_rd_mux[DATA_WIDTH-1:0] = (r_dir & r_out) | (~r_dir & r_s2);
      c_ADDR_DIR:  w_rd_mux[DATA_WIDTH-1:0] = r_dir;
      c_ADDR_MASK: w_rd_mux[DATA_WIDTH-1:0] = r_mask;
      c_ADDR_EDGE: w_rd_mux[DATA_WIDTH-1:0] = r_edge;
      default:     w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out      <= RESET_VALUE;
      r_dir      <= DIR_RESET;
      r_mask     <= '0;
      r_edge     <= '0;
      r_s1       <= '0;
      r_s2       <= '0;
      r_s3       <= '0;
      r_irq      <= 1'b0;
      r_readdata <= '0;
    end else begin
      r_s1   <= pio_in;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_out  <= w_out_nxt;
      r_edge <= w_edge_nxt;
      // irq follows the registered state, so it trails any EDGE/mask change by one cycle.
      r_irq  <= |(r_edge & r_mask);
      if (w_wr_dir) begin
        r_dir <= w_wdata;
      end
      if (w_wr_mask) begin
        r_mask <= w_wdata;
      end
      if (bus.read) begin
        r_readdata <= w_rd_mux;
      end
    end
  end

  assign pio_out      = r_out;
  assign pio_oe       = r_dir;
  assign irq          = r_irq;
  assign bus.readdata = r_readdata;

endmodule
`default_nettype wire
